wgt_glb_streamer: RTL

- Port controller and row streamer for the weight global buffer (64 x 8-bit default), acting as its only master.
- Upstream side: single-cycle writes (overwrite or add) pass through to the buffer.
- Read side: on command, reads a contiguous, wrapping range of rows and streams them to the PE array over a valid/ready interface, hiding the buffer's one-cycle read latency with a 2-entry skid FIFO.
- Also sequences whole-buffer clears by driving the buffer's active-low ready.

---
 rtl/wgt_glb_streamer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wgt_glb_streamer.sv
// Port controller and row streamer for the weight global buffer.
// It is the buffer's only master. It passes upstream writes through,
// sequences whole-buffer clears, and streams a wrapping range of rows to the
// PE array. A 2-entry skid FIFO hides the buffer's one-cycle read latency.
module wgt_glb_streamer #(
  parameter int WGT_GLB_NUM_ROWS   = 64,
  parameter int WGT_GLB_ADDR_WIDTH = $clog2(WGT_GLB_NUM_ROWS),
  parameter int WGT_GLB_NUM_BITS   = 8
) (
  input  logic                          w_clock,
  input  logic                          w_reset_n,
  input  logic                          w_clear,
  input  logic                          w_start,
  input  logic [WGT_GLB_ADDR_WIDTH-1:0] w_base_addr,
  input  logic [WGT_GLB_ADDR_WIDTH:0]   w_count,
  output logic                          w_busy,
  output logic                          w_done,
  input  logic                          w_wr_valid,
  output logic                          w_wr_ready,
  input  logic                          w_wr_add,
  input  logic [WGT_GLB_ADDR_WIDTH-1:0] w_wr_addr,
  input  logic [WGT_GLB_NUM_BITS-1:0]   w_wr_data,
  output logic                          w_out_valid,
  input  logic                          w_out_ready,
  output logic [WGT_GLB_NUM_BITS-1:0]   w_out_data,
  output logic                          w_out_last,
  output logic                          w_glb_ready,
  output logic                          w_glb_rw,
  output logic                          w_glb_add,
  output logic [WGT_GLB_ADDR_WIDTH-1:0] w_glb_address,
  output logic [WGT_GLB_NUM_BITS-1:0]   w_glb_data_in,
  input  logic [WGT_GLB_NUM_BITS-1:0]   w_glb_data_out
);

  localparam int AW = WGT_GLB_ADDR_WIDTH;
  localparam int DW = WGT_GLB_NUM_BITS;
  localparam logic [AW:0] NUM_ROWS_W = (AW+1)'(WGT_GLB_NUM_ROWS);

  typedef enum logic [1:0] {IDLE, CLEAR, READ, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] base_q;
  logic [AW:0]   count_q;
  logic [AW:0]   issue_q;
  logic [AW:0]   beat_q;
  logic          inflight_q;
  logic [DW-1:0] fifo_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    occ_q;
  logic [1:0]    occ_d;

  logic          idle;
  logic          wr_fire;
  logic          push;
  logic          pop;
  logic [2:0]    pending;
  logic          issue;
  logic [AW:0]   addr_sum;
  logic [AW:0]   addr_wrap;
  logic          last_beat;

  // Handshakes, read credit and the wrapped issue address
  always_comb begin
    idle       = (state_q == IDLE);
    w_wr_ready = idle && !w_clear && !w_start && w_reset_n;
    wr_fire    = w_wr_ready && w_wr_valid;
    push       = inflight_q;
    pop        = (occ_q != 2'd0) && w_out_ready;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    // Issuing is allowed only if the read would still find a FIFO slot free
    // once it lands, counting reads already in flight and a pop this cycle.
    pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == READ) && (issue_q < count_q) && (pending < 3'd2);
    addr_sum   = {1'b0, base_q} + issue_q;
    addr_wrap  = (addr_sum >= NUM_ROWS_W) ? (addr_sum - NUM_ROWS_W) : addr_sum;
    last_beat  = (beat_q == (count_q - 1'b1));
  end

  // Buffer port drive and stream outputs
  always_comb begin
    w_busy        = (state_q != IDLE);
    w_done        = (state_q == DONE);
    w_out_valid   = (occ_q != 2'd0);
    w_out_data    = fifo_q[rd_ptr_q];
    w_out_last    = w_out_valid && last_beat;
    w_glb_ready   = w_reset_n && (state_q != CLEAR);
    w_glb_rw      = wr_fire;
    w_glb_add     = wr_fire && w_wr_add;
    w_glb_data_in = wr_fire ? w_wr_data : '0;
    if (wr_fire)
      w_glb_address = w_wr_addr;
    else if (state_q == READ)
      w_glb_address = addr_wrap[AW-1:0];
    else
      w_glb_address = '0;
  end

  // Control FSM: command acceptance, issue/beat counting and burst completion
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issue_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      case (state_q)
        IDLE: begin
          if (w_clear) begin
            state_q <= CLEAR;
          end else if (w_start) begin
            base_q  <= w_base_addr;
            count_q <= w_count;
            issue_q <= '0;
            beat_q  <= '0;
            state_q <= (w_count == '0) ? DONE : READ;
          end
        end
        CLEAR: state_q <= DONE;
        READ: begin
          if (issue) issue_q <= issue_q + 1'b1;
          if (pop) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry skid FIFO catching read data one cycle after each issue
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= w_glb_data_out;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

endmodule
